// File: rtl/cov_matrix_loader.sv
// rtl/cov_matrix_loader.sv - serial-to-parallel covariance matrix loader
// Full row-major or upper-triangle (mirrored) input, held until acknowledged.
module cov_matrix_loader #(
  parameter int WIDTH    = 16,
  parameter int FRACT    = 8,
  parameter int N_STOCKS = 4
) (
  input  logic                                                clk_in,
  input  logic                                                rst_in,
  input  logic signed [WIDTH-1:0]                             data_in,
  input  logic                                                data_valid_in,
  output logic                                                data_ready_out,
  input  logic                                                sym_mode_in,
  output logic signed [N_STOCKS-1:0][N_STOCKS-1:0][WIDTH-1:0] matrix_out,
  output logic                                                matrix_valid_out,
  input  logic                                                matrix_ack_in,
  output logic [$clog2(N_STOCKS*N_STOCKS+1)-1:0]              count_out
);

  localparam int IW = (N_STOCKS > 1) ? $clog2(N_STOCKS) : 1;
  localparam int CW = $clog2(N_STOCKS*N_STOCKS+1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_STOCKS - 1);

  if (N_STOCKS < 1 || N_STOCKS > 16 || FRACT < 0 || FRACT >= WIDTH) begin : g_bad_params
    $error("cov_matrix_loader: illegal parameter combination");
  end

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FULL} state_t;

  state_t                                              r_state;
  logic [IW-1:0]                                       r_row;
  logic [IW-1:0]                                       r_col;
  logic                                                r_sym;
  logic [CW-1:0]                                       r_count;
  logic                                                r_valid;
  logic                                                r_ready;
  logic signed [N_STOCKS-1:0][N_STOCKS-1:0][WIDTH-1:0] r_matrix;

  logic w_accept;
  logic w_sym;
  logic w_last;

  assign w_accept = data_valid_in && r_ready && (r_state != S_FULL);
  // The format is taken live on the opening beat, latched thereafter.
  assign w_sym    = (r_state == S_IDLE) ? sym_mode_in : r_sym;
  // Both formats end on the bottom-right diagonal element.
  assign w_last   = (r_row == LAST_IDX) && (r_col == LAST_IDX);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state  <= S_IDLE;
      r_row    <= '0;
      r_col    <= '0;
      r_sym    <= 1'b0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_ready  <= 1'b0;
      r_matrix <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_LOAD: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            if (r_state == S_IDLE) begin
              r_sym <= sym_mode_in;
            end
            r_matrix[r_row][r_col] <= data_in;
            if (w_sym) begin
              r_matrix[r_col][r_row] <= data_in;
            end
            r_count <= r_count + 1'b1;
            if (w_last) begin
              r_state <= S_FULL;
              r_valid <= 1'b1;
              r_ready <= 1'b0;
              r_row   <= '0;
              r_col   <= '0;
            end else begin
              r_state <= S_LOAD;
              if (r_col == LAST_IDX) begin
                r_row <= r_row + 1'b1;
                r_col <= w_sym ? (r_row + 1'b1) : '0;
              end else begin
                r_col <= r_col + 1'b1;
              end
            end
          end
        end
        S_FULL: begin
          if (matrix_ack_in) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_count <= '0;
            r_row   <= '0;
            r_col   <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign data_ready_out   = r_ready;
  assign matrix_out       = r_matrix;
  assign matrix_valid_out = r_valid;
  assign count_out        = r_count;

endmodule

// File: doc/cov_matrix_loader.md
Name: cov_matrix_loader

Overview:
- Receives an N_STOCKS x N_STOCKS signed fixed-point covariance matrix as a serial element stream over a valid/ready handshake.
- Assembles the elements into a parallel register array that feeds the convergence checker and the rotation datapath.
- Supports two input formats: full row-major, or upper-triangle-only with mirroring for symmetric matrices.
- Holds the completed matrix stable until the consumer acknowledges it.

Parameters:
- WIDTH, 16, element width in bits (signed two's complement).
- FRACT, 8, fractional bits. The loader stores data unchanged; this parameter is documentation only.
- N_STOCKS, 4, matrix dimension. Legal range is 1 to 16.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous active-high reset.
- data_in  input  signed [WIDTH-1:0]  matrix element, in stream order.
- data_valid_in  input  1  data_in is valid this cycle.
- data_ready_out  output  1  loader can accept a beat this cycle.
- sym_mode_in  input  1  selects the format: 1 = upper triangle, 0 = full matrix. Sampled only on the first beat of a matrix.
- matrix_out  output  signed [WIDTH-1:0] [N_STOCKS-1:0][N_STOCKS-1:0]  assembled matrix, registered.
- matrix_valid_out  output  1  matrix_out is complete and stable.
- matrix_ack_in  input  1  consumer has taken the matrix.
- count_out  output  $clog2(N_STOCKS*N_STOCKS+1)  number of beats accepted for the current matrix.

Behaviour:
- One clock domain, clk_in. Reset is synchronous and active-high on rst_in.
- All outputs are registered.
- A beat is accepted on any rising edge where data_valid_in and data_ready_out are both high.
- States:
  - IDLE: no matrix in progress.
  - LOAD: matrix partially received.
  - FULL: matrix complete, waiting for acknowledge.
- Reset values: state=IDLE, every matrix_out entry=0, matrix_valid_out=0, count_out=0, row/col indices=0, sym latch=0. data_ready_out=0 in the reset cycle and 1 from the first cycle after reset deasserts.
- data_ready_out is 1 in IDLE and LOAD, and 0 in FULL.
- IDLE, beat accepted:
  - sym_mode_in is latched.
  - The element is written to [0][0].
  - Next state is LOAD, or FULL if that beat was the last one (N_STOCKS=1).
- Full format (latched sym=0):
  - N*N beats, row-major.
  - Beat k is written to [k/N][k%N].
  - col wraps N-1 -> 0 and row increments.
- Symmetric format (latched sym=1):
  - N(N+1)/2 beats, row-major over the upper triangle including the diagonal.
  - Within row i, col runs i..N-1. After col=N-1, row increments and col restarts at the new row index.
  - Each element is written to both [i][j] and [j][i] in the same cycle. Diagonal entries are written once.
- LOAD: matrix_out entries update one cycle after each accepted beat. Partial contents are not guaranteed meaningful while matrix_valid_out=0.
- Last beat accepted: on the next cycle matrix_valid_out=1, state=FULL and data_ready_out=0. This is 1-cycle latency from the final accept.
- FULL:
  - matrix_out and count_out are frozen.
  - data_valid_in is ignored, with no accept and no write.
  - matrix_ack_in=1 causes, on the next cycle: matrix_valid_out=0, state=IDLE, data_ready_out=1, count_out=0, indices=0.
- matrix_out contents after acknowledge:
  - Contents are retained, not cleared, after acknowledge.
  - In full mode they are fully overwritten by the next matrix.
  - In symmetric mode every entry is overwritten via the mirror writes.
- matrix_ack_in outside FULL is ignored.
- sym_mode_in changes during LOAD are ignored.
- Gaps in data_valid_in during LOAD hold all state. There is no timeout.
- Reset mid-load or in FULL returns everything to the reset values. Partial data is discarded and the matrix is zeroed.
- Element values pass through bit-exact, with no saturation or rescaling. Negative values are preserved.
- count_out increments by 1 per accepted beat, max N*N.

Test Plan:
- Identity load. Full mode, N=4, 16 beats, 16'h0100 on the diagonal and 0 elsewhere, driven back-to-back. Expect data_ready_out=1 throughout; matrix_valid_out rises exactly 1 cycle after the 16th accept; [2][2]=16'h0100; [1][3]=0; count_out=16.
- Symmetric load. sym=1, 10 beats with values 1..10. Expect [0][3]=[3][0]=4, [1][2]=[2][1]=6, [1][1]=5, [3][3]=10; valid 1 cycle after the 10th beat; count_out=10.
- Backpressure. Hold data_valid_in=1 with data 16'hFF00 while in FULL for 5 cycles: no accepts and matrix unchanged. Then pulse matrix_ack_in: the next cycle has valid=0 and ready=1, and the held beat is accepted into [0][0]=16'hFF00 (sign preserved).
- Bubbles and mode latch. Full mode with data_valid_in toggling every other cycle and sym_mode_in flipped to 1 after beat 3. Expect a correct full-matrix result after 16 accepts, ignoring the sym change.
- Reset mid-load. Assert rst_in for 1 cycle after 7 beats. Expect all matrix_out=0, count_out=0, valid=0, and ready=0 during reset then 1. A fresh 16-beat load completes normally.
- Spurious acknowledge. Pulse matrix_ack_in in IDLE and in LOAD. Expect no state change; count_out and matrix are unaffected.
